// File: rtl/uart_mem_pkg.sv
// Shared definitions for the UART-to-memory command path.
// Holds the controller state encoding and the byte values of the
// command opcodes and single-byte responses on the UART link.
package uart_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        WRITE,
        READ_WAIT,
        READ_CAP,
        SEND,
        WAIT_DONE
    } state_t;

    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
    localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

endpackage

// File: rtl/uart_mem_cmd_ctrl_timeout.sv
// frame_timeout: inter-byte watchdog for UART frame parsers.
// The counter is reloaded with LIMIT while clear is high and counts down
// while enable is high. expired pulses for one cycle on the LIMIT-th
// consecutive enabled, uncleared cycle, then the counter reloads.
//   clk, reset : clock, synchronous active-high reset
//   clear      : reload (wins over enable)
//   enable     : count this cycle
//   expired    : one-cycle expiry pulse (combinational from count)
module frame_timeout #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign expired = enable && !clear && (count == CW'(1));

    always_ff @(posedge clk) begin
        if (reset || clear || expired) begin
            count <= CW'(LIMIT);
        end else if (enable) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_mem_cmd_ctrl.sv
// uart_mem_cmd_ctrl: byte-command sequencer between the UART RX/TX pair and
// a single-port word memory. Write frame: 0x57, addr, NB data bytes (MSB
// first) -> one memory write, reply 0x4B. Read frame: 0x52, addr -> NB bytes
// of the word, MSB first. Unknown opcode -> reply 0x3F.
//   clk, reset            : clock, synchronous active-high reset
//   rx_data / rx_valid    : received byte and its one-cycle strobe
//   tx_data / tx_start    : byte to send and one-cycle send request
//   tx_done               : transmitter finished the current byte
//   mem_addr/mem_wdata    : memory address and write data
//   mem_wr_en             : one-cycle write strobe
//   mem_rdata             : read data, valid one cycle after mem_addr
//   busy                  : controller not in IDLE
//   err_cmd/err_timeout/err_overrun : one-cycle error pulses
module uart_mem_cmd_ctrl
    import uart_mem_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DBITS-1:0]  rx_data,
    input  logic              rx_valid,
    output logic [DBITS-1:0]  tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_wr_en,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              busy,
    output logic              err_cmd,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int NB = WIDTH / DBITS;
    localparam int CW = $clog2(NB + 1);

    state_t           state;
    logic             op_read;
    logic [CW-1:0]    byte_cnt;
    logic [CW-1:0]    remaining;
    logic [WIDTH-1:0] tx_shift;
    logic             counting;
    logic             tmo_clear;
    logic             tmo_expired;

    // Single response bytes are placed in the top byte of the TX shift
    // register so they leave through the same path as read payload.
    function automatic logic [WIDTH-1:0] rsp_word(input logic [7:0] code);
        return WIDTH'(DBITS'(code)) << (WIDTH - DBITS);
    endfunction

    assign counting  = (state == GET_ADDR) || (state == GET_DATA);
    assign tmo_clear = rx_valid || !counting;
    assign busy      = (state != IDLE);
    assign tx_data   = tx_shift[WIDTH-1 -: DBITS];

    frame_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (counting),
        .expired (tmo_expired)
    );

    // Pulse outputs are registered: they are set on the transition into the
    // state they belong to, so mem_wr_en is high exactly while in WRITE and
    // tx_start exactly while in SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_read     <= 1'b0;
            byte_cnt    <= '0;
            remaining   <= '0;
            tx_shift    <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wr_en   <= 1'b0;
            tx_start    <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            mem_wr_en   <= 1'b0;
            tx_start    <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == DBITS'(OP_WR)) begin
                            op_read <= 1'b0;
                            state   <= GET_ADDR;
                        end else if (rx_data == DBITS'(OP_RD)) begin
                            op_read <= 1'b1;
                            state   <= GET_ADDR;
                        end else begin
                            err_cmd   <= 1'b1;
                            tx_shift  <= rsp_word(RSP_ERR);
                            remaining <= CW'(1);
                            tx_start  <= 1'b1;
                            state     <= SEND;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_valid) begin
                        mem_addr <= ADDR_W'(rx_data);
                        if (op_read) begin
                            state <= READ_WAIT;
                        end else begin
                            byte_cnt <= '0;
                            state    <= GET_DATA;
                        end
                    end else if (tmo_expired) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                GET_DATA: begin
                    if (rx_valid) begin
                        mem_wdata <= (mem_wdata << DBITS) | WIDTH'(rx_data);
                        if (byte_cnt == CW'(NB - 1)) begin
                            mem_wr_en <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (tmo_expired) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WRITE: begin
                    tx_shift  <= rsp_word(RSP_ACK);
                    remaining <= CW'(1);
                    tx_start  <= 1'b1;
                    state     <= SEND;
                end
                READ_WAIT: begin
                    state <= READ_CAP;
                end
                READ_CAP: begin
                    tx_shift  <= mem_rdata;
                    remaining <= CW'(NB);
                    tx_start  <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CW'(1)) begin
                            state <= IDLE;
                        end else begin
                            tx_shift <= tx_shift << DBITS;
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (rx_valid && (state inside {WRITE, READ_WAIT, READ_CAP, SEND, WAIT_DONE})) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
// Directed bench for uart_mem_cmd_ctrl: a vector table of complete frames
// plus hand-written sequences for timeout, overrun, reset mid-read and
// back-to-back frames. A behavioural memory and transmitter surround the DUT.
module tb_uart_mem_cmd_ctrl;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err_cmd;
    logic        err_timeout;
    logic        err_overrun;

    always #5 clk = ~clk;

    uart_mem_cmd_ctrl #(
        .DBITS   (8),
        .WIDTH   (32),
        .ADDR_W  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wr_en   (mem_wr_en),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .err_cmd     (err_cmd),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory with one-cycle read latency, plus write log and error-pulse counters.
    logic [31:0] mem [256];
    logic [39:0] wr_log [$];
    int n_cmd_p = 0;
    int n_tmo_p = 0;
    int n_ovr_p = 0;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
            wr_log.push_back({mem_addr, mem_wdata});
        end
        if (err_cmd)     n_cmd_p <= n_cmd_p + 1;
        if (err_timeout) n_tmo_p <= n_tmo_p + 1;
        if (err_overrun) n_ovr_p <= n_ovr_p + 1;
    end

    // Transmitter: records each requested byte, answers tx_done 3 cycles later.
    logic [7:0] txq [$];
    int tx_cnt;
    bit tx_pend;

    initial begin
        tx_done = 1'b0;
        tx_pend = 1'b0;
        tx_cnt  = 0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (reset) begin
                tx_pend = 1'b0;
            end else if (tx_start) begin
                check("tx_start_while_pending", 64'(tx_pend), 64'd0);
                txq.push_back(tx_data);
                tx_cnt  = 2;
                tx_pend = 1'b1;
            end else if (tx_pend) begin
                if (tx_cnt == 0) begin
                    tx_done = 1'b1;
                    tx_pend = 1'b0;
                end else begin
                    tx_cnt--;
                end
            end
        end
    end

    function automatic logic [7:0] txb(input int i);
        return (i < txq.size()) ? txq[i] : 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check({nm, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_tx(input int n, input string nm);
        for (int i = 0; i < 300; i++) begin
            if (txq.size() >= n) break;
            @(posedge clk);
        end
        check({nm, " tx_wait"}, 64'(txq.size() >= n), 64'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] w, input string nm);
        int b;
        b = txq.size();
        send_byte(8'h52);
        send_byte(a);
        wait_idle(nm);
        check({nm, " tx_count"}, 64'(txq.size() - b), 64'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s byte%0d", nm, k), 64'(txb(b + k)), 64'(w[31 - 8*k -: 8]));
    endtask

    typedef struct {
        logic [7:0]  rx [6];
        int          n_rx;
        logic [7:0]  tx [4];
        int          n_tx;
        int          n_wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          n_cmd;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int tb, wb, cb, ob, qb;

        vecs[0] = '{'{8'h57, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 6, '{8'h4B, 8'h00, 8'h00, 8'h00}, 1, 1, 8'h03, 32'hDEADBEEF, 0};
        vecs[1] = '{'{8'h52, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 2, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 4, 0, 8'h00, 32'h0, 0};
        vecs[2] = '{'{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{8'h3F, 8'h00, 8'h00, 8'h00}, 1, 0, 8'h00, 32'h0, 1};
        vecs[3] = '{'{8'h57, 8'h05, 8'h0B, 8'hAD, 8'hF0, 8'h0D}, 6, '{8'h4B, 8'h00, 8'h00, 8'h00}, 1, 1, 8'h05, 32'h0BADF00D, 0};
        vecs[4] = '{'{8'h57, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78}, 6, '{8'h4B, 8'h00, 8'h00, 8'h00}, 1, 1, 8'hFF, 32'h12345678, 0};
        vecs[5] = '{'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{8'h3F, 8'h00, 8'h00, 8'h00}, 1, 0, 8'h00, 32'h0, 1};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset busy",        64'(busy),        64'd0);
        check("reset tx_start",    64'(tx_start),    64'd0);
        check("reset mem_wr_en",   64'(mem_wr_en),   64'd0);
        check("reset err_cmd",     64'(err_cmd),     64'd0);
        check("reset err_timeout", 64'(err_timeout), 64'd0);
        check("reset err_overrun", 64'(err_overrun), 64'd0);
        check("reset mem_addr",    64'(mem_addr),    64'd0);
        check("reset mem_wdata",   64'(mem_wdata),   64'd0);
        check("reset tx_data",     64'(tx_data),     64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < NV; v++) begin
            tb = txq.size();
            wb = wr_log.size();
            cb = n_cmd_p;
            ob = n_ovr_p;
            for (int k = 0; k < vecs[v].n_rx; k++) send_byte(vecs[v].rx[k]);
            wait_idle($sformatf("v%0d", v));
            @(negedge clk);
            check($sformatf("v%0d tx_count", v), 64'(txq.size() - tb), 64'(vecs[v].n_tx));
            for (int k = 0; k < vecs[v].n_tx; k++)
                check($sformatf("v%0d tx_byte%0d", v, k), 64'(txb(tb + k)), 64'(vecs[v].tx[k]));
            check($sformatf("v%0d writes", v), 64'(wr_log.size() - wb), 64'(vecs[v].n_wr));
            if (vecs[v].n_wr == 1 && wr_log.size() > wb)
                check($sformatf("v%0d write_entry", v), 64'(wr_log[wb]), 64'({vecs[v].addr, vecs[v].wdata}));
            check($sformatf("v%0d err_cmd", v), 64'(n_cmd_p - cb), 64'(vecs[v].n_cmd));
            check($sformatf("v%0d err_overrun", v), 64'(n_ovr_p - ob), 64'd0);
        end

        // Timeout mid-frame: no write, no response, exactly one err_timeout
        tb = txq.size();
        wb = wr_log.size();
        qb = n_tmo_p;
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TMO - 10) @(negedge clk);
        check("tmo early_pulse", 64'(n_tmo_p - qb), 64'd0);
        check("tmo early_busy",  64'(busy),         64'd1);
        repeat (20) @(negedge clk);
        check("tmo pulse",  64'(n_tmo_p - qb),         64'd1);
        check("tmo busy",   64'(busy),                 64'd0);
        check("tmo writes", 64'(wr_log.size() - wb),   64'd0);
        check("tmo tx",     64'(txq.size() - tb),      64'd0);
        do_read(8'h05, 32'h0BADF00D, "tmo readback");

        // Overrun during WAIT_DONE: byte dropped, read completes, back in IDLE
        tb = txq.size();
        ob = n_ovr_p;
        cb = n_cmd_p;
        send_byte(8'h52);
        send_byte(8'h03);
        wait_tx(tb + 1, "ovr");
        send_byte(8'h57);
        wait_idle("ovr");
        check("ovr pulse",    64'(n_ovr_p - ob),     64'd1);
        check("ovr err_cmd",  64'(n_cmd_p - cb),     64'd0);
        check("ovr tx_count", 64'(txq.size() - tb),  64'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("ovr byte%0d", k), 64'(txb(tb + k)), 64'(32'hDEADBEEF >> (24 - 8*k)) & 64'hFF);
        do_read(8'hFF, 32'h12345678, "ovr next_read");

        // Reset mid-read after the second tx_start
        tb = txq.size();
        send_byte(8'h52);
        send_byte(8'h03);
        wait_tx(tb + 2, "rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst busy",      64'(busy),      64'd0);
        check("rst tx_start",  64'(tx_start),  64'd0);
        check("rst mem_wr_en", 64'(mem_wr_en), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tb = txq.size();
        wb = wr_log.size();
        send_byte(8'h57);
        send_byte(8'hFF);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'hC3);
        send_byte(8'h3C);
        wait_idle("rst write");
        check("rst write ack_count", 64'(txq.size() - tb),   64'd1);
        check("rst write ack",       64'(txb(tb)),           64'h4B);
        check("rst write count",     64'(wr_log.size() - wb), 64'd1);
        if (wr_log.size() > wb)
            check("rst write entry", 64'(wr_log[wb]), 64'({8'hFF, 32'hA55AC33C}));

        // Back-to-back write frames, second starting right after the first ack
        tb = txq.size();
        wb = wr_log.size();
        ob = n_ovr_p;
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (tx_done) break;
        end
        check("b2b first_done", 64'(tx_done), 64'd1);
        send_byte(8'h57);
        send_byte(8'h02);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        wait_idle("b2b");
        check("b2b overrun",  64'(n_ovr_p - ob),      64'd0);
        check("b2b writes",   64'(wr_log.size() - wb), 64'd2);
        if (wr_log.size() >= wb + 2) begin
            check("b2b write0", 64'(wr_log[wb]),     64'({8'h01, 32'h01020304}));
            check("b2b write1", 64'(wr_log[wb + 1]), 64'({8'h02, 32'h05060708}));
        end
        check("b2b acks",  64'(txq.size() - tb), 64'd2);
        check("b2b ack0",  64'(txb(tb)),         64'h4B);
        check("b2b ack1",  64'(txb(tb + 1)),     64'h4B);
        do_read(8'h01, 32'h01020304, "b2b read1");
        do_read(8'h02, 32'h05060708, "b2b read2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_mem_cmd_ctrl.md
Name: uart_mem_cmd_ctrl

Overview:
Byte-command sequencer between the UART receiver/transmitter pair and the single-port word memory (mem_single). It parses a small binary command stream from RX, assembles bytes into WIDTH-bit words and writes them at a host-given address. On read commands it reads a word and serialises it back over TX. It replaces ad-hoc harness glue with the memory's only access master, so no other writer touches the port.

Parameters:
DBITS, 8, UART byte width
WIDTH, 32, memory word width; must be an integer multiple of DBITS
ADDR_W, 8, memory address width (memory holds 2**ADDR_W words)
TIMEOUT, 1000000, idle clk cycles allowed between bytes of one frame before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
rx_data  in  DBITS  received byte, valid when rx_valid=1
rx_valid  in  1  one-cycle pulse per received byte
tx_data  out  DBITS  byte to transmit, stable from tx_start until tx_done
tx_start  out  1  one-cycle request to transmitter
tx_done  in  1  one-cycle pulse: transmitter finished current byte
mem_addr  out  ADDR_W  memory address
mem_wdata  out  WIDTH  memory write data
mem_wr_en  out  1  one-cycle write strobe
mem_rdata  in  WIDTH  memory read data, valid 1 cycle after mem_addr is applied
busy  out  1  high in any state other than IDLE
err_cmd  out  1  one-cycle pulse: unknown opcode
err_timeout  out  1  one-cycle pulse: frame aborted by timeout
err_overrun  out  1  one-cycle pulse: byte dropped because controller not accepting

Behaviour:
- Reset: state IDLE; all outputs 0; byte counter, timeout counter and word shift register cleared. Reset mid-frame or mid-TX drops everything immediately; tx_start is 0 in the cycle after reset.
- NB = WIDTH/DBITS (4 at defaults). Words are sent and received MSB byte first.
- Frames: write = 0x57, addr, NB data bytes. Read = 0x52, addr. Only the low ADDR_W bits of the address byte are used; the address byte is zero-extended if ADDR_W > DBITS.
- States: IDLE, GET_ADDR, GET_DATA, WRITE, READ_WAIT, READ_CAP, SEND, WAIT_DONE.
- IDLE, on rx_valid:
  - 0x57 -> GET_ADDR with op=write.
  - 0x52 -> GET_ADDR with op=read.
  - Any other byte -> err_cmd pulse, load tx byte 0x3F, go to SEND.
- GET_ADDR, on rx_valid: latch mem_addr. Write goes to GET_DATA with byte count 0. Read goes to READ_WAIT.
- GET_DATA: each rx_valid shifts the byte into the low end of mem_wdata (left shift by DBITS). After the NB-th byte, go to WRITE.
- WRITE: mem_wr_en=1 for exactly one cycle, then load ack byte 0x4B and go to SEND.
- READ_WAIT: one cycle for memory latency. READ_CAP: capture mem_rdata into the TX shift register, set remaining=NB, go to SEND.
- SEND: drive tx_data = current byte and pulse tx_start for one cycle, then go to WAIT_DONE.
- WAIT_DONE, on tx_done:
  - Read payload: decrement remaining. If nonzero, shift the next byte up and return to SEND; otherwise go to IDLE.
  - Single response byte (0x3F or 0x4B): go to IDLE.
- Latency: write ack tx_start occurs 2 cycles after the last data byte's rx_valid. Read first tx_start occurs 3 cycles after the address byte's rx_valid.
- Timeout counter resets on every rx_valid. It counts only in GET_ADDR and GET_DATA. On reaching TIMEOUT: pulse err_timeout, go to IDLE, no write, no response byte.
- rx_valid in WRITE, READ_WAIT, READ_CAP, SEND or WAIT_DONE: byte discarded, err_overrun pulsed, state unaffected.
- A tx_done outside WAIT_DONE is ignored.
- mem_wr_en is never asserted outside WRITE. mem_addr holds its last value in IDLE.
- Address wraps naturally at 2**ADDR_W; there is no auto-increment.

Decomposition:
- Shared package uart_mem_pkg:
  - state enum;
  - opcode constants OP_WR=0x57 and OP_RD=0x52;
  - response constants RSP_ACK=0x4B and RSP_ERR=0x3F.
- The FSM, counters and shift registers stay in one module.
- One natural sub-module: frame_timeout (loadable down-counter with clear, enable and expire pulse), reusable by other UART frame parsers.

Test Plan:
1. Write then read: RX 57 03 DE AD BE EF -> one mem_wr_en with addr=0x03, wdata=0xDEADBEEF; TX 4B. Then RX 52 03 -> TX DE AD BE EF in order, busy low after the last tx_done.
2. Unknown opcode: RX 0x41 -> err_cmd pulse; TX 3F; no mem_wr_en; IDLE.
3. Timeout: RX 57 05 11 22 then silence for TIMEOUT+10 cycles -> err_timeout exactly once; no write; next frame 52 05 returns the prior contents of addr 5.
4. Overrun: RX 52 00, then inject rx_valid byte 0x57 during WAIT_DONE -> err_overrun pulse; read response completes unchanged; controller returns to IDLE, not GET_ADDR.
5. Reset mid-read: assert reset after the second tx_start of a read -> next cycle busy=0, tx_start=0, mem_wr_en=0; a subsequent write frame to addr 0xFF succeeds with ack 4B.
6. Back-to-back: frame 57 01 + 4 bytes sent immediately after the previous 4B tx_done -> no overrun; both writes land; tx_start never asserted while tx_done is pending.
